uart_rx: RTL

- Serial receiver for the team's Hamming-protected UART link.
- Samples the line at bit centres and deserialises one frame: 1 start bit (0), 13 codeword bits LSB first, 1 stop bit (1).
- Decodes the 13-bit SECDED codeword back to 8 data bits, corrects single-bit errors, and flags double-bit errors.
- Sits at the far end of the link from uart_tx; must interoperate with it at the same divisor.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_hamming_decoder.sv | 62 ++++++
 rtl/uart_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the Hamming-protected UART receiver.
// Bit positions match the transmit-side encoder exactly.
package uart_rx_pkg;

    localparam int unsigned CODE_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYN_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } state_e;

    // Codeword bit index of each data bit d0..d7, and of the Hamming parity bits
    localparam int unsigned DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};
    localparam int unsigned PAR_POS  [SYN_W]  = '{0, 1, 3, 7};
    localparam int unsigned OVR_POS           = 12;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corrected;
        logic              uncorrectable;
    } dec_result_t;

endpackage

// File: rtl/uart_rx_hamming_decoder.sv
// Combinational SECDED decoder: 13-bit codeword to 8 data bits plus error flags.
module hamming_decoder
    import uart_rx_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output dec_result_t       result_c
);

    logic [SYN_W-1:0]  syn;
    logic              par;
    logic [CODE_W-1:0] fixed;
    logic              corr;
    logic              unc;

    // Syndrome over the Hamming-covered bits; overall parity over the whole word
    always_comb begin
        syn = '0;
        for (int i = 0; i < int'(CODE_W) - 1; i++) begin
            for (int k = 0; k < int'(SYN_W); k++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    syn[k] = syn[k] ^ code_i[i];
                end
            end
        end
        par = ^code_i;
    end

    // Odd overall parity means a single flip; syndrome points at it, or at the
    // overall-parity bit when zero. Syndromes past the word are unrecoverable.
    always_comb begin
        fixed = code_i;
        corr  = 1'b0;
        unc   = 1'b0;
        if (par) begin
            if (syn == '0) begin
                fixed[OVR_POS] = ~code_i[OVR_POS];
                corr           = 1'b1;
            end else if (syn > SYN_W'(CODE_W - 1)) begin
                unc = 1'b1;
            end else begin
                for (int i = 0; i < int'(CODE_W) - 1; i++) begin
                    if (syn == SYN_W'(i + 1)) begin
                        fixed[i] = ~code_i[i];
                    end
                end
                corr = 1'b1;
            end
        end else if (syn != '0) begin
            unc = 1'b1;
        end
    end

    always_comb begin
        result_c.data = '0;
        for (int j = 0; j < int'(DATA_W); j++) begin
            result_c.data[j] = fixed[DATA_POS[j]];
        end
        result_c.corrected     = corr;
        result_c.uncorrectable = unc;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-samples one start, 13 codeword and one stop bit,
// then registers the SECDED-decoded byte with correction/detection flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIVISOR = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    output logic              frame_err
);

    localparam int unsigned CNT_W = 11;
    localparam int unsigned BIT_W = 4;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CODE_W - 1);

    logic              rx_meta_q, rx_s_q;
    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CODE_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              corr_q, corr_d;
    logic              unc_q, unc_d;
    logic              ferr_q, ferr_d;
    dec_result_t       dec_c;

    hamming_decoder u_dec (
        .code_i   (shift_q),
        .result_c (dec_c)
    );

    // Two-flop synchroniser for the asynchronous line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Armed tracks "line seen high" so a stuck-low line cannot retrigger a frame
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q | rx_s_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        corr_d    = corr_q;
        unc_d     = unc_q;
        ferr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && !rx_s_q) begin
                    state_d   = ST_START;
                    clk_cnt_d = '0;
                    armed_d   = 1'b0;
                end
            end
            ST_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = CNT_W'(clk_cnt_q + 1'b1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_cnt_q] = rx_s_q;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = BIT_W'(bit_cnt_q + 1'b1);
                    end
                end else begin
                    clk_cnt_d = CNT_W'(clk_cnt_q + 1'b1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_DONE;
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    clk_cnt_d = CNT_W'(clk_cnt_q + 1'b1);
                end
            end
            ST_DONE: begin
                data_d  = dec_c.data;
                corr_d  = dec_c.corrected;
                unc_d   = dec_c.uncorrectable;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            corr_q    <= 1'b0;
            unc_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            corr_q    <= corr_d;
            unc_q     <= unc_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data              = data_q;
    assign valid             = valid_q;
    assign err_corrected     = corr_q;
    assign err_uncorrectable = unc_q;
    assign frame_err         = ferr_q;

endmodule
